// File: rtl/fir_s2p_framer_if.sv
// Stream bundle between the sample source and the 3-lane frame consumer.
// The slave modport is the framer's view; the master modport is the driver's view.
interface fir_s2p_framer_if #(
  parameter int unsigned NB    = 11,
  parameter int unsigned CNT_W = 16
) ();
  logic [NB-1:0]    din;
  logic             vin;
  logic             flush;
  logic [NB-1:0]    dout0;
  logic [NB-1:0]    dout1;
  logic [NB-1:0]    dout2;
  logic             vout;
  logic [CNT_W-1:0] frame_cnt;
  logic             partial;

  modport slave (
    input  din, vin, flush,
    output dout0, dout1, dout2, vout, frame_cnt, partial
  );

  modport master (
    output din, vin, flush,
    input  dout0, dout1, dout2, vout, frame_cnt, partial
  );
endinterface

// File: rtl/fir_s2p_framer.sv
// Serial-to-parallel framer: packs the sample stream into 3-sample frames for the
// unfolded FIR lanes, with flush of a zero-padded partial frame at end of stream.
module fir_s2p_framer #(
  parameter int unsigned NB    = 11,
  parameter int unsigned CNT_W = 16
) (
  input  logic              CLK_i,
  input  logic              RST_n,
  fir_s2p_framer_if.slave   bus
);

  typedef enum logic [1:0] {StFill0, StFill1, StFill2} state_e;

  state_e           idx_q;
  logic [NB-1:0]    s0_q, s1_q;
  logic [NB-1:0]    dout0_q, dout1_q, dout2_q;
  logic             vout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             partial_q;

  logic             emit;
  logic [NB-1:0]    f0, f1, f2;

  // The third sample never needs a slot: a capture at StFill2 always emits directly.
  // s1_q is zero whenever idx_q is StFill1, so a flush can emit it unconditionally.
  always_comb begin
    emit = 1'b0;
    f0   = s0_q;
    f1   = s1_q;
    f2   = '0;
    if (bus.vin) begin
      unique case (idx_q)
        StFill0: begin f0 = bus.din; emit = bus.flush; end
        StFill1: begin f1 = bus.din; emit = bus.flush; end
        StFill2: begin f2 = bus.din; emit = 1'b1;      end
        default: ;
      endcase
    end else if (bus.flush && idx_q != StFill0) begin
      emit = 1'b1;
    end
  end

  always_ff @(posedge CLK_i or negedge RST_n) begin
    if (!RST_n) begin
      idx_q     <= StFill0;
      s0_q      <= '0;
      s1_q      <= '0;
      dout0_q   <= '0;
      dout1_q   <= '0;
      dout2_q   <= '0;
      vout_q    <= 1'b0;
      cnt_q     <= '0;
      partial_q <= 1'b0;
    end else begin
      vout_q <= emit;
      if (emit) begin
        dout0_q   <= f0;
        dout1_q   <= f1;
        dout2_q   <= f2;
        cnt_q     <= cnt_q + 1'b1;
        idx_q     <= StFill0;
        s0_q      <= '0;
        s1_q      <= '0;
        partial_q <= 1'b0;
      end else if (bus.vin) begin
        unique case (idx_q)
          StFill0: begin s0_q <= bus.din; idx_q <= StFill1; partial_q <= 1'b1; end
          StFill1: begin s1_q <= bus.din; idx_q <= StFill2; end
          default: ;
        endcase
      end
    end
  end

  assign bus.dout0     = dout0_q;
  assign bus.dout1     = dout1_q;
  assign bus.dout2     = dout2_q;
  assign bus.vout      = vout_q;
  assign bus.frame_cnt = cnt_q;
  assign bus.partial   = partial_q;

endmodule

// File: tb/tb_fir_s2p_framer.sv
// Bench for fir_s2p_framer: directed scenarios with literal expectations, then random
// traffic against a queue-based frame model; a 4-bit-counter instance covers wrap.
module tb_fir_s2p_framer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] din;
  logic        vin, flush;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fir_s2p_framer_if #(.NB(11), .CNT_W(16)) bus16 ();
  fir_s2p_framer_if #(.NB(11), .CNT_W(4))  bus4 ();

  assign bus16.din = din;
  assign bus16.vin = vin;
  assign bus16.flush = flush;
  assign bus4.din = din;
  assign bus4.vin = vin;
  assign bus4.flush = flush;

  fir_s2p_framer #(.NB(11), .CNT_W(16)) dut16 (.CLK_i(clk), .RST_n(rst_n), .bus(bus16));
  fir_s2p_framer #(.NB(11), .CNT_W(4))  dut4  (.CLK_i(clk), .RST_n(rst_n), .bus(bus4));

  // Reference: pending samples in a queue; a frame leaves when three are queued or
  // when flush finds anything queued, padded with zeros.
  logic [10:0] mq[$];
  logic [10:0] m_d[3];
  logic        m_v, m_p;
  int unsigned m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_d = '{default: '0};
      m_v = 1'b0;
      m_p = 1'b0;
      m_cnt = 0;
    end else begin
      m_v = 1'b0;
      if (vin) mq.push_back(din);
      if (mq.size() == 3 || (flush && mq.size() > 0)) begin
        for (int i = 0; i < 3; i++) m_d[i] = (i < mq.size()) ? mq[i] : 11'd0;
        m_v = 1'b1;
        m_cnt++;
        mq.delete();
      end
      m_p = (mq.size() != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("m.vout16", 32'(bus16.vout), 32'(m_v));
      chk("m.vout4", 32'(bus4.vout), 32'(m_v));
      chk("m.partial16", 32'(bus16.partial), 32'(m_p));
      chk("m.partial4", 32'(bus4.partial), 32'(m_p));
      chk("m.dout0", 32'(bus16.dout0), 32'(m_d[0]));
      chk("m.dout1", 32'(bus16.dout1), 32'(m_d[1]));
      chk("m.dout2", 32'(bus16.dout2), 32'(m_d[2]));
      chk("m.dout0_4", 32'(bus4.dout0), 32'(m_d[0]));
      chk("m.dout1_4", 32'(bus4.dout1), 32'(m_d[1]));
      chk("m.dout2_4", 32'(bus4.dout2), 32'(m_d[2]));
      chk("m.cnt16", 32'(bus16.frame_cnt), 32'(m_cnt[15:0]));
      chk("m.cnt4", 32'(bus4.frame_cnt), 32'(m_cnt[3:0]));
    end
  end

  // Drive one cycle; returns #1 after the edge so outputs reflect that edge.
  task automatic send(input logic v, input logic f, input logic [10:0] d);
    vin = v;
    flush = f;
    din = d;
    @(posedge clk);
    #1;
    vin = 1'b0;
    flush = 1'b0;
    din = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 11'd0);
  endtask

  task automatic chk_out(input string name, input logic v, input logic [10:0] a,
                         input logic [10:0] b, input logic [10:0] c);
    chk({name, ".vout"}, 32'(bus16.vout), 32'(v));
    chk({name, ".d0"}, 32'(bus16.dout0), 32'(a));
    chk({name, ".d1"}, 32'(bus16.dout1), 32'(b));
    chk({name, ".d2"}, 32'(bus16.dout2), 32'(c));
    chk({name, ".d0_4"}, 32'(bus4.dout0), 32'(a));
  endtask

  initial begin
    int cnt_before;
    rst_n = 1'b0;
    vin = 1'b0;
    flush = 1'b0;
    din = '0;
    #3;
    chk_out("reset", 1'b0, 11'd0, 11'd0, 11'd0);
    chk("reset.cnt", 32'(bus16.frame_cnt), 32'd0);
    chk("reset.partial", 32'(bus16.partial), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Back-to-back frames
    send(1'b1, 1'b0, 11'd1);
    chk("b2b.partial1", 32'(bus16.partial), 32'd1);
    send(1'b1, 1'b0, 11'd2);
    chk("b2b.partial2", 32'(bus16.partial), 32'd1);
    send(1'b1, 1'b0, 11'd3);
    chk("b2b.partial3", 32'(bus16.partial), 32'd0);
    chk_out("b2b.f1", 1'b1, 11'd1, 11'd2, 11'd3);
    send(1'b1, 1'b0, 11'd4);
    chk("b2b.gap", 32'(bus16.vout), 32'd0);
    send(1'b1, 1'b0, 11'd5);
    send(1'b1, 1'b0, 11'd6);
    chk_out("b2b.f2", 1'b1, 11'd4, 11'd5, 11'd6);
    chk("b2b.cnt", 32'(bus16.frame_cnt), 32'd2);

    // Extreme values with gaps; 11'h400 is -1024, 11'h3FF is 1023
    send(1'b1, 1'b0, 11'h400);
    send(1'b1, 1'b0, 11'd7);
    idle(5);
    send(1'b1, 1'b0, 11'h3FF);
    chk_out("gaps.frame", 1'b1, 11'h400, 11'd7, 11'h3FF);
    idle(2);
    chk_out("gaps.hold", 1'b0, 11'h400, 11'd7, 11'h3FF);

    // Flush of a partial frame, then a redundant flush
    cnt_before = int'(bus16.frame_cnt);
    send(1'b1, 1'b0, 11'd10);
    send(1'b1, 1'b0, 11'd20);
    send(1'b0, 1'b1, 11'd0);
    chk_out("flush.frame", 1'b1, 11'd10, 11'd20, 11'd0);
    chk("flush.cnt", 32'(bus16.frame_cnt), 32'(cnt_before + 1));
    send(1'b0, 1'b1, 11'd0);
    chk("flush.again", 32'(bus16.vout), 32'd0);

    // Flush together with a capture
    send(1'b1, 1'b0, 11'd5);
    send(1'b1, 1'b1, 11'd9);
    chk_out("flushvin.idx1", 1'b1, 11'd5, 11'd9, 11'd0);
    cnt_before = int'(bus16.frame_cnt);
    send(1'b1, 1'b0, 11'd1);
    send(1'b1, 1'b0, 11'd2);
    send(1'b1, 1'b1, 11'd3);
    chk_out("flushvin.idx2", 1'b1, 11'd1, 11'd2, 11'd3);
    chk("flushvin.cnt", 32'(bus16.frame_cnt), 32'(cnt_before + 1));
    send(1'b1, 1'b1, 11'd42);
    chk_out("flushvin.idx0", 1'b1, 11'd42, 11'd0, 11'd0);

    // Asynchronous reset mid-frame
    send(1'b1, 1'b0, 11'd100);
    send(1'b1, 1'b0, 11'd200);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("areset", 1'b0, 11'd0, 11'd0, 11'd0);
    chk("areset.cnt", 32'(bus16.frame_cnt), 32'd0);
    chk("areset.partial", 32'(bus16.partial), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1'b1, 1'b0, 11'd1);
    send(1'b1, 1'b0, 11'd2);
    send(1'b1, 1'b0, 11'd3);
    chk_out("postrst", 1'b1, 11'd1, 11'd2, 11'd3);
    chk("postrst.cnt", 32'(bus16.frame_cnt), 32'd1);

    // Counter wrap on the 4-bit instance
    for (int k = 0; k < 14; k++) begin
      send(1'b1, 1'b0, 11'(k));
      send(1'b1, 1'b0, 11'(k + 1));
      send(1'b1, 1'b0, 11'(k + 2));
    end
    chk("wrap.cnt4_15", 32'(bus4.frame_cnt), 32'd15);
    send(1'b1, 1'b0, 11'd11);
    send(1'b1, 1'b0, 11'd22);
    send(1'b1, 1'b0, 11'd33);
    chk("wrap.cnt4_0", 32'(bus4.frame_cnt), 32'd0);
    chk("wrap.cnt16", 32'(bus16.frame_cnt), 32'd16);
    chk("wrap.vout4", 32'(bus4.vout), 32'd1);
    chk("wrap.d2_4", 32'(bus4.dout2), 32'd33);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      send(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), 11'($urandom));
    end
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_s2p_framer.md
Name: fir_s2p_framer

Overview:
- Upstream stage of the 3-way unfolded FIR.
- Accepts the serial sample stream from the data generator (one 11-bit sample per valid cycle) and packs consecutive samples into 3-sample parallel frames for the unfolded filter's three input lanes.
- Tolerates gaps in VIN.
- Supports an end-of-stream FLUSH that zero-pads and emits a partial frame.
- Counts emitted frames for bench bookkeeping.

Parameters:
- NB, 11, sample width in bits (two's complement).
- CNT_W, 16, width of the frame counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- DIN  in  NB  signed input sample.
- VIN  in  1  DIN valid; sample captured on a rising CLK edge where VIN=1.
- FLUSH  in  1  end-of-stream request; emit any partial frame, zero-padded.
- DOUT0  out  NB  frame lane 0: oldest sample, stream index 3k.
- DOUT1  out  NB  frame lane 1: stream index 3k+1.
- DOUT2  out  NB  frame lane 2: stream index 3k+2.
- VOUT  out  1  DOUT0..2 hold a new frame; one-cycle pulse per frame.
- FRAME_CNT  out  CNT_W  number of frames emitted since reset; wraps modulo 2^CNT_W.
- PARTIAL  out  1  high when the staging buffer holds 1 or 2 samples.

Behaviour:
- Reset (async, RST_n=0): the following clear immediately and hold until RST_n=1.
  - idx=0; staging slots S0..S2=0.
  - DOUT0..2=0, VOUT=0, FRAME_CNT=0, PARTIAL=0.
  - Reset mid-frame discards the partial frame; no VOUT is produced for it.
- State: slot index idx in {0,1,2}, i.e. three states FILL0/FILL1/FILL2. PARTIAL = (idx!=0), registered.
- Capture: on a rising edge with VIN=1, DIN is written to S[idx].
  - idx<2: idx advances by 1.
  - idx=2: frame completes.
- VIN=0 and FLUSH=0: all state holds (gaps of any length allowed). DOUT0..2 keep the last emitted frame; VOUT=0.
- Frame emit, registered, on the same edge as the completing capture:
  - DOUT0..2 are loaded with {S0, S1, DIN}.
  - VOUT=1 for exactly the following cycle.
  - FRAME_CNT increments; idx returns to 0; S0..S2 clear to 0.
  - Latency: VOUT is high in the cycle right after the edge that captured the 3rd sample.
  - Back-to-back frames: with VIN held high, VOUT pulses every 3rd cycle.
- FLUSH with idx!=0 and VIN=0: emit {S0, S1 or 0, 0} per the current fill. Unfilled slots are emitted as 0. Counter updates and idx reset are the same as a normal emit.
- FLUSH with idx=0 and VIN=0: no effect; no VOUT and no counter change.
- FLUSH and VIN in the same cycle: the sample is captured first, then the frame is emitted.
  - idx=0: emit {DIN, 0, 0}.
  - idx=1: emit {S0, DIN, 0}.
  - idx=2: normal full emit, counted once.
- FLUSH held high across cycles: each cycle is evaluated independently. After an emit idx=0, so a held FLUSH without VIN produces no further frames.
- Arithmetic: samples are passed bit-exact, with no sign extension or rounding. FRAME_CNT wraps from 2^CNT_W-1 to 0 silently.
- No backpressure: the downstream unfolded FIR consumes every frame. VOUT is not gated by any downstream signal.

Test Plan:
- Reset, then VIN=1 for 6 cycles with DIN=1,2,3,4,5,6 → VOUT pulses after the 3rd and 6th captures. Frames are {1,2,3} then {4,5,6}; FRAME_CNT=2; PARTIAL toggles 1,1,0 per frame.
- DIN=-1024,7,1023 interleaved with VIN=0 gaps of 0, 5 and 2 cycles → a single frame {-1024,7,1023}. VOUT is seen exactly once, one cycle after the 3rd capture. DOUT0..2 then hold that frame while VOUT=0.
- Capture 10,20, then a FLUSH-only cycle → frame {10,20,0}, FRAME_CNT+1. A second FLUSH-only cycle produces no VOUT.
- Capture 5, then FLUSH and VIN together with DIN=9 → frame {5,9,0}. With idx=2 and FLUSH+VIN, DIN=3 after 1,2 → frame {1,2,3}, counted once.
- Capture 100,200, assert RST_n=0 mid-cycle → outputs go to 0 immediately, with no clock edge needed. After release, 1,2,3 → frame {1,2,3}, FRAME_CNT=1.
- Force the counter near wrap using CNT_W=4 and 16 frames → FRAME_CNT goes 15→0 with no other side effects.
